// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types and constants for the 5-stage pipeline
// hazard/sequencing controller.
//   fwd_sel_e    : EX operand source select (none / MEM result / WB result)
//   ctrl_state_e : controller sequencing state
//   REG_ZERO     : architectural $zero, never a forwarding source
//   CNT_W        : width of the shared MDU/drain down-counter
//   sat_inc      : saturating 32-bit increment for the optional perf counters
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } ctrl_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Wide enough for MDU_LATENCY-1 up to 62 and DRAIN_CYCLES-1 up to 14.
  localparam int CNT_W = 6;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_fwd_unit.sv
// pipeline_fwd_unit: purely combinational forwarding compare for one EX
// operand. The MEM-stage result has priority over the WB-stage result;
// $zero never forwards. The register file is write-before-read, so no ID
// forwarding is needed.
// Ports:
//   src           in  5  source register of the instruction now in EX
//   mem_rd        in  5  MEM destination
//   mem_reg_write in  1  MEM writes register file
//   wb_rd         in  5  WB destination
//   wb_reg_write  in  1  WB writes register file
//   sel           out 2  operand source select (fwd_sel_e encoding)
module pipeline_fwd_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output logic [1:0] sel
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_reg_write && (mem_rd != REG_ZERO) && (mem_rd == src);
  assign wb_hit  = wb_reg_write  && (wb_rd  != REG_ZERO) && (wb_rd  == src);

  always_comb begin
    sel = FWD_NONE;
    if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central hazard and sequencing controller for the 5-stage
// MIPS pipeline. Produces PC/IF-ID stall, ID-EX bubble, IF-ID flush and EX
// operand forwarding selects; holds the pipe for multi-cycle mult/div; drains
// and halts the core once the halt PC has been fetched.
// Optional build macro PIPELINE_CTRL_PERF_EN adds saturating performance
// counters stall_cycles / flush_count / mdu_cycles.
// Ports:
//   clk, rst (async, active-low)
//   next_pc                       fetch address (halt detect)
//   id_rs/id_rt, id_uses_rs/rt    ID source operands
//   id_mdu_start                  ID instruction is mult/div
//   ex_rd, ex_reg_write, ex_mem_read, ex_branch_taken   EX stage status
//   mem_rd/mem_reg_write, wb_rd/wb_reg_write            later-stage writers
//   pc_stall, if_id_stall, id_ex_bubble, if_id_flush    pipeline control
//   fwd_a, fwd_b                  EX operand source selects
//   mdu_busy, halted              status
//   dbg_state                     current controller state (ctrl_state_e)
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [31:0] HALT_PC      = 32'h8008_8008,
  parameter int          DRAIN_CYCLES = 4,
  parameter int          MDU_LATENCY  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_mdu_start,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_branch_taken,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic        wb_reg_write,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        mdu_busy,
  output logic        halted,
  output logic [1:0]  dbg_state
`ifdef PIPELINE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
  output logic [31:0] mdu_cycles
`endif
);

  localparam logic [CNT_W-1:0] MDU_LOAD   = CNT_W'(MDU_LATENCY - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  ctrl_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             halt_hit;
  logic [4:0]       ex_rs, ex_rt;
  logic             load_use;

  logic pc_stall_s, if_id_stall_s, id_ex_bubble_s, if_id_flush_s;

  assign load_use = ex_mem_read && (ex_rd != REG_ZERO) &&
                    ((id_uses_rs && (ex_rd == id_rs)) ||
                     (id_uses_rt && (ex_rd == id_rt)));

  // State register, down-counter and registered halt-PC compare.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      cnt      <= '0;
      halt_hit <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      halt_hit <= (next_pc == HALT_PC);
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    pc_stall_s     = 1'b0;
    if_id_stall_s  = 1'b0;
    id_ex_bubble_s = 1'b0;
    if_id_flush_s  = 1'b0;
    case (state)
      RUN: begin
        // A taken branch wins over load-use: the PC must take the target.
        pc_stall_s     = load_use && !ex_branch_taken;
        if_id_stall_s  = load_use && !ex_branch_taken;
        id_ex_bubble_s = load_use || ex_branch_taken;
        if_id_flush_s  = ex_branch_taken;
        // MDU start beats halt; halt_hit stays true while the PC is held,
        // so the halt is taken once the MDU finishes.
        if (id_mdu_start && !load_use && !ex_branch_taken) begin
          state_nxt = MDU_WAIT;
          cnt_nxt   = MDU_LOAD;
        end else if (halt_hit) begin
          state_nxt = DRAIN;
          cnt_nxt   = DRAIN_LOAD;
        end
      end
      MDU_WAIT: begin
        pc_stall_s     = 1'b1;
        if_id_stall_s  = 1'b1;
        id_ex_bubble_s = 1'b1;
        if (cnt == '0) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DRAIN: begin
        pc_stall_s    = 1'b1;
        if_id_flush_s = 1'b1;
        if (cnt == '0) begin
          state_nxt = HALTED;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      HALTED: begin
        pc_stall_s     = 1'b1;
        if_id_flush_s  = 1'b1;
        id_ex_bubble_s = 1'b1;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // While reset is asserted the PC is held and nothing else is requested.
  assign pc_stall     = !rst || pc_stall_s;
  assign if_id_stall  = rst && if_id_stall_s;
  assign id_ex_bubble = rst && id_ex_bubble_s;
  assign if_id_flush  = rst && if_id_flush_s;
  assign mdu_busy     = rst && (state == MDU_WAIT);
  assign halted       = rst && (state == HALTED);
  assign dbg_state    = state;

  // EX copies of the ID source registers. ID/EX only ever advances or takes
  // a bubble; a bubble leaves $zero so nothing forwards to the NOP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_rs <= REG_ZERO;
      ex_rt <= REG_ZERO;
    end else if (id_ex_bubble) begin
      ex_rs <= REG_ZERO;
      ex_rt <= REG_ZERO;
    end else begin
      ex_rs <= id_rs;
      ex_rt <= id_rt;
    end
  end

  pipeline_fwd_unit u_fwd_a (
    .src           (ex_rs),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd_a)
  );

  pipeline_fwd_unit u_fwd_b (
    .src           (ex_rt),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd_b)
  );

`ifdef PIPELINE_CTRL_PERF_EN
  // Counters only advance in RUN/MDU_WAIT, so they freeze once HALTED.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
      mdu_cycles   <= '0;
    end else begin
      if (((state == RUN) || (state == MDU_WAIT)) && pc_stall) begin
        stall_cycles <= sat_inc(stall_cycles);
      end
      if ((state == RUN) && if_id_flush) begin
        flush_count <= sat_inc(flush_count);
      end
      if (state == MDU_WAIT) begin
        mdu_cycles <= sat_inc(mdu_cycles);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed + randomized bench for pipeline_ctrl.
// Expected outputs come from a cycle-level reference model that tracks
// "cycles left" for multiply and drain instead of an FSM.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam logic [31:0] T_HALT_PC  = 32'h8008_8008;
  localparam int          T_DRAIN    = 4;
  localparam int          T_MDU      = 32;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic [31:0] next_pc;
  logic [4:0]  id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic        id_uses_rs, id_uses_rt, id_mdu_start;
  logic        ex_reg_write, ex_mem_read, ex_branch_taken;
  logic        mem_reg_write, wb_reg_write;
  logic        pc_stall, if_id_stall, id_ex_bubble, if_id_flush;
  logic [1:0]  fwd_a, fwd_b, dbg_state;
  logic        mdu_busy, halted;

  pipeline_ctrl #(
    .HALT_PC      (T_HALT_PC),
    .DRAIN_CYCLES (T_DRAIN),
    .MDU_LATENCY  (T_MDU)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .next_pc         (next_pc),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_mdu_start    (id_mdu_start),
    .ex_rd           (ex_rd),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .mem_rd          (mem_rd),
    .mem_reg_write   (mem_reg_write),
    .wb_rd           (wb_rd),
    .wb_reg_write    (wb_reg_write),
    .pc_stall        (pc_stall),
    .if_id_stall     (if_id_stall),
    .id_ex_bubble    (id_ex_bubble),
    .if_id_flush     (if_id_flush),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .mdu_busy        (mdu_busy),
    .halted          (halted),
    .dbg_state       (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int   m_mdu_left   = 0;  // multiply stall cycles still owed
  int   m_drain_left = 0;  // drain cycles still owed
  bit   m_halted     = 0;
  bit   m_halt_seen  = 0;  // halt PC was presented last cycle
  logic [4:0] m_ex_rs = 5'd0;
  logic [4:0] m_ex_rt = 5'd0;

  // Last sampled DUT outputs, for directed checks against constants.
  logic       last_pc, last_ifs, last_bub, last_fl, last_busy, last_halt;
  logic [1:0] last_fa, last_fb, last_st;

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (src != 5'd0 && mem_reg_write && mem_rd == src) return 2'd1;
    if (src != 5'd0 && wb_reg_write && wb_rd == src) return 2'd2;
    return 2'd0;
  endfunction

  // Called at posedge+1 once inputs are set: checks at the falling edge,
  // advances the model, and returns at the next posedge+1.
  task automatic cycle_check();
    logic e_pc, e_ifs, e_bub, e_fl, e_busy, e_halt;
    logic [1:0] e_fa, e_fb, e_st;
    bit lu, br;
    #4;
    lu = ex_mem_read && ex_rd != 5'd0 &&
         ((id_uses_rs && ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt));
    br = ex_branch_taken;
    e_pc = 0; e_ifs = 0; e_bub = 0; e_fl = 0; e_busy = 0; e_halt = 0;
    e_fa = 2'd0; e_fb = 2'd0; e_st = 2'd0;
    if (!rst) begin
      e_pc = 1;
    end else begin
      e_fa = ref_fwd(m_ex_rs);
      e_fb = ref_fwd(m_ex_rt);
      if (m_halted) begin
        e_halt = 1; e_pc = 1; e_fl = 1; e_bub = 1; e_st = 2'd3;
      end else if (m_mdu_left > 0) begin
        e_busy = 1; e_pc = 1; e_ifs = 1; e_bub = 1; e_st = 2'd1;
      end else if (m_drain_left > 0) begin
        e_pc = 1; e_fl = 1; e_st = 2'd2;
      end else begin
        e_pc = lu && !br; e_ifs = lu && !br; e_bub = lu || br; e_fl = br;
      end
    end
    last_pc = pc_stall; last_ifs = if_id_stall; last_bub = id_ex_bubble;
    last_fl = if_id_flush; last_fa = fwd_a; last_fb = fwd_b;
    last_busy = mdu_busy; last_halt = halted; last_st = dbg_state;
    chk("pc_stall",     32'(pc_stall),     32'(e_pc));
    chk("if_id_stall",  32'(if_id_stall),  32'(e_ifs));
    chk("id_ex_bubble", 32'(id_ex_bubble), 32'(e_bub));
    chk("if_id_flush",  32'(if_id_flush),  32'(e_fl));
    chk("fwd_a",        32'(fwd_a),        32'(e_fa));
    chk("fwd_b",        32'(fwd_b),        32'(e_fb));
    chk("mdu_busy",     32'(mdu_busy),     32'(e_busy));
    chk("halted",       32'(halted),       32'(e_halt));
    chk("state",        32'(dbg_state),    32'(e_st));
    // advance the model to the next cycle
    if (!rst) begin
      m_mdu_left = 0; m_drain_left = 0; m_halted = 0; m_halt_seen = 0;
      m_ex_rs = 5'd0; m_ex_rt = 5'd0;
    end else begin
      if (m_halted) begin
        // terminal
      end else if (m_mdu_left > 0) begin
        m_mdu_left--;
      end else if (m_drain_left > 0) begin
        m_drain_left--;
        if (m_drain_left == 0) m_halted = 1;
      end else if (id_mdu_start && !lu && !br) begin
        m_mdu_left = T_MDU;
      end else if (m_halt_seen) begin
        m_drain_left = T_DRAIN;
      end
      m_halt_seen = (next_pc == T_HALT_PC);
      m_ex_rs = e_bub ? 5'd0 : id_rs;
      m_ex_rt = e_bub ? 5'd0 : id_rt;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    next_pc = 32'h0000_1000;
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 0; id_uses_rt = 0;
    id_mdu_start = 0;
    ex_rd = 5'd0; ex_reg_write = 0; ex_mem_read = 0; ex_branch_taken = 0;
    mem_rd = 5'd0; mem_reg_write = 0; wb_rd = 5'd0; wb_reg_write = 0;
  endtask

  task automatic drive_random();
    next_pc = $urandom & 32'h0FFF_FFFC;
    id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
    id_uses_rs = 1'($urandom_range(0, 1)); id_uses_rt = 1'($urandom_range(0, 1));
    id_mdu_start = ($urandom_range(0, 19) == 0);
    ex_rd = 5'($urandom_range(0, 3));
    ex_reg_write = 1'($urandom_range(0, 1));
    ex_mem_read = 1'($urandom_range(0, 1));
    ex_branch_taken = ($urandom_range(0, 5) == 0);
    mem_rd = 5'($urandom_range(0, 3)); mem_reg_write = 1'($urandom_range(0, 1));
    wb_rd = 5'($urandom_range(0, 3)); wb_reg_write = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset(input int n);
    clear_inputs();
    rst = 0;
    for (int i = 0; i < n; i++) cycle_check();
    rst = 1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    bit reached;
    clear_inputs();
    rst = 0;
    @(posedge clk);
    #1;

    // 1: reset held 3 cycles, then release
    for (int i = 0; i < 3; i++) cycle_check();
    chk("reset_pc_stall", 32'(last_pc), 32'd1);
    chk("reset_bubble", 32'(last_bub), 32'd0);
    rst = 1;
    cycle_check();
    chk("rel_pc_stall", 32'(last_pc), 32'd0);
    chk("rel_halted", 32'(last_halt), 32'd0);
    chk("rel_state", 32'(last_st), 32'd0);

    // 2: load-use on $t0
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1;
    cycle_check();
    chk("lu_pc_stall", 32'(last_pc), 32'd1);
    chk("lu_if_id_stall", 32'(last_ifs), 32'd1);
    chk("lu_bubble", 32'(last_bub), 32'd1);
    ex_mem_read = 0; ex_reg_write = 0; ex_rd = 5'd0;
    cycle_check();
    chk("lu_after_pc_stall", 32'(last_pc), 32'd0);
    chk("lu_after_bubble", 32'(last_bub), 32'd0);

    // 3: forwarding priority and $zero
    id_rs = 5'd9;
    cycle_check();
    mem_reg_write = 1; mem_rd = 5'd9; wb_reg_write = 1; wb_rd = 5'd9;
    cycle_check();
    chk("fwd_mem_prio", 32'(last_fa), 32'(FWD_MEM));
    mem_reg_write = 0; id_rs = 5'd0; id_rt = 5'd9;
    cycle_check();
    chk("fwd_wb_only", 32'(last_fa), 32'(FWD_WB));
    mem_reg_write = 1; mem_rd = 5'd0; wb_rd = 5'd0;
    cycle_check();
    chk("fwd_zero", 32'(last_fa), 32'(FWD_NONE));
    wb_rd = 5'd9;
    cycle_check();
    chk("fwd_b_wb", 32'(last_fb), 32'(FWD_WB));
    clear_inputs();
    cycle_check();

    // 4: load-use together with taken branch
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1;
    ex_branch_taken = 1;
    cycle_check();
    chk("br_flush", 32'(last_fl), 32'd1);
    chk("br_bubble", 32'(last_bub), 32'd1);
    chk("br_pc_stall", 32'(last_pc), 32'd0);
    clear_inputs();
    cycle_check();

    // 5: multiply holds the pipe for MDU_LATENCY cycles
    id_mdu_start = 1;
    cycle_check();
    id_mdu_start = 0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      cycle_check();
      if (last_busy === 1'b1) n++;
      else if (n > 0) break;
    end
    chk("mdu_busy_cycles", 32'(n), 32'(T_MDU));
    chk("mdu_back_to_run", 32'(last_st), 32'd0);

    // random phase
    for (int i = 0; i < 400; i++) begin
      drive_random();
      cycle_check();
    end

    // 6a: halt PC -> drain -> halted, and halted sticks
    do_reset(2);
    cycle_check();
    next_pc = T_HALT_PC;
    cycle_check();
    reached = 0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle_check();
      if (last_halt === 1'b1) begin
        reached = 1;
        n = i;
        break;
      end
    end
    chk("halt_reached", 32'(reached), 32'd1);
    chk("halt_latency", 32'(n), 32'(1 + T_DRAIN + 1));
    next_pc = 32'h0000_2000;
    for (int i = 0; i < 5; i++) cycle_check();
    chk("halt_sticky", 32'(last_halt), 32'd1);

    // 6b: MDU start beats pending halt; halt resumes after; reset mid-drain
    do_reset(2);
    cycle_check();
    next_pc = T_HALT_PC;
    cycle_check();
    id_mdu_start = 1;
    cycle_check();
    id_mdu_start = 0;
    cycle_check();
    chk("mdu_wins_over_halt", 32'(last_st), 32'd1);
    reached = 0;
    for (int i = 0; i < 60; i++) begin
      cycle_check();
      if (last_st === 2'd2) begin
        reached = 1;
        break;
      end
    end
    chk("drain_after_mdu", 32'(reached), 32'd1);
    cycle_check();
    rst = 0;
    cycle_check();
    chk("rst_mid_drain_halted", 32'(last_halt), 32'd0);
    chk("rst_mid_drain_state", 32'(last_st), 32'd0);
    rst = 1;
    next_pc = 32'h0000_3000;
    cycle_check();
    chk("after_rst_run", 32'(last_pc), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB), instantiated in proc_top beside the datapath.
- Generates PC/IF-ID stall, ID-EX bubble and IF-ID flush.
- Generates operand forwarding selects.
- Holds the pipeline during multi-cycle multiply/divide operations.
- Drains and halts the core when the halt PC is fetched, so benches stop on a `halted` flag instead of fixed delays.

Parameters:
- HALT_PC, 32'h80088008, fetch address that triggers drain/halt.
- DRAIN_CYCLES, 4, cycles allowed for in-flight instructions to retire after halt detect (1..15).
- MDU_LATENCY, 32, EX-stage cycles for a mult/div (2..63).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low (asserted when 0), single clock domain.
- next_pc  input  32  PC being presented to fetch.
- id_rs, id_rt  input  5 each  source registers of instruction in ID.
- id_uses_rs, id_uses_rt  input  1 each  ID instruction reads rs/rt.
- id_mdu_start  input  1  ID instruction is mult/div.
- ex_rd  input  5  EX destination.
- ex_reg_write  input  1  EX writes register file.
- ex_mem_read  input  1  EX is a load.
- ex_branch_taken  input  1  branch/jump resolved taken in EX.
- mem_rd  input  5  MEM destination.
- mem_reg_write  input  1  MEM writes register file.
- wb_rd  input  5  WB destination.
- wb_reg_write  input  1  WB writes register file.
- pc_stall  output  1  hold PC.
- if_id_stall  output  1  hold IF/ID register.
- id_ex_bubble  output  1  load NOP into ID/EX.
- if_id_flush  output  1  load NOP into IF/ID.
- fwd_a, fwd_b  output  2 each  operand source select for EX operands A/B.
- mdu_busy  output  1  multi-cycle op in progress.
- halted  output  1  core halted.

Behaviour:
Reset (rst=0, async):
- State = RUN; all counters 0.
- halted=0, mdu_busy=0.
- All stall/flush/bubble outputs are combinational from state; during reset they read 0 except pc_stall=1.

Forwarding (combinational, register-file write-before-read assumed):
- fwd_a = FWD_MEM when mem_reg_write & mem_rd!=0 & mem_rd==EX rs; else FWD_WB when the same test holds for WB; else FWD_NONE.
- MEM has priority over WB.
- fwd_b uses the same rule on rt.
- Register 0 never forwards.
- Controller registers id_rs/id_rt into EX copies when ID/EX advances, i.e. not stalled. On bubble the copies are set to 0.

Load-use hazard:
- Detect: ex_mem_read & ex_rd!=0 & ((id_uses_rs & ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)).
- Response: pc_stall=1, if_id_stall=1, id_ex_bubble=1 for exactly one cycle per occurrence.

Branch:
- ex_branch_taken gives if_id_flush=1 and id_ex_bubble=1 the same cycle.
- Flush overrides load-use: pc_stall=0, since PC must take the branch target.

States:
- RUN: normal operation, hazard logic active.
  - id_mdu_start with no stall/flush that cycle -> MDU_WAIT, counter=MDU_LATENCY-1.
  - Registered compare next_pc==HALT_PC -> DRAIN, counter=DRAIN_CYCLES-1.
  - MDU start and halt detect in the same cycle: MDU wins; the halt compare is re-evaluated in RUN afterwards.
- MDU_WAIT:
  - mdu_busy=1, pc_stall=1, if_id_stall=1, id_ex_bubble=1.
  - Counter decrements each cycle; at 0 -> RUN.
  - ex_branch_taken is ignored (cannot occur; MDU instruction occupies EX).
- DRAIN:
  - pc_stall=1, if_id_flush=1 (no new instructions); forwarding stays active.
  - Counter decrements; at 0 -> HALTED.
- HALTED:
  - halted=1, pc_stall=1, if_id_flush=1, id_ex_bubble=1.
  - Terminal; exits only on reset.

Reset asserted mid-MDU or mid-drain returns to RUN immediately with counters cleared.

Optional Feature:
PIPELINE_CTRL_PERF_EN
- Defined: adds outputs stall_cycles[31:0], flush_count[31:0] and mdu_cycles[31:0], all async-cleared.
  - stall_cycles increments on any cycle with pc_stall=1 in RUN/MDU_WAIT.
  - flush_count increments per if_id_flush in RUN.
  - mdu_cycles increments per cycle in MDU_WAIT.
  - All three saturate at all-ones and freeze in HALTED.
- Undefined: ports and logic absent.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - typedef enum logic [1:0] fwd_sel_e {FWD_NONE=0, FWD_MEM=1, FWD_WB=2};
  - typedef enum ctrl_state_e {RUN, MDU_WAIT, DRAIN, HALTED};
  - REG_ZERO constant.
- One sub-module, pipeline_fwd_unit: the pure combinational forwarding compare, instantiated once per operand.

Test Plan:
1. Reset held low 3 cycles, release -> halted=0, mdu_busy=0, pc_stall=0 one cycle after release, state RUN.
2. Load to $t0 in EX (ex_mem_read=1, ex_rd=8), ID reads rs=8 -> one cycle of pc_stall=if_id_stall=id_ex_bubble=1, then 0.
3. MEM writes rd=9 and WB writes rd=9, EX rs=9 -> fwd_a=FWD_MEM. WB only -> FWD_WB. rd=0 writing -> FWD_NONE.
4. Load-use hazard and ex_branch_taken same cycle -> if_id_flush=1, id_ex_bubble=1, pc_stall=0.
5. id_mdu_start with MDU_LATENCY=32 -> mdu_busy=1 and stalls for exactly 32 cycles, then RUN.
6. next_pc=32'h80088008 -> after DRAIN_CYCLES=4, halted=1 and stays 1. Reset asserted during DRAIN -> halted=0, RUN.
